fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction prefetch queue with flush/redirect handling
module fetch_queue #(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        inst_mem_is_ready,
    output logic [31:0] inst_mem_address,
    input  logic        inst_mem_is_valid,
    input  logic [31:0] inst_mem_read_data,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_fetch_pc,
    output logic        exception
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] occ_q, occ_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          exc_q, exc_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pcs_q [DEPTH];
    logic          issue, resp_drop, resp_keep, push, pop;
    logic [CW-1:0] inflight_ret, drop_ret;
    logic [CW:0]   drop_sum;
    logic [31:0]   resp_pc;

    // A slot is free only if neither buffered nor already promised to an outstanding request.
    assign issue     = !reset && !flush && !exc_q &&
                       ({1'b0, occ_q} + {1'b0, inflight_q} < {1'b0, DEPTH_C});
    // Stale responses sit ahead of live ones, so the drop counter is consumed first.
    assign resp_drop = inst_mem_is_valid && drop_q != '0;
    assign resp_keep = inst_mem_is_valid && drop_q == '0 && inflight_q != '0;
    assign push      = resp_keep && !flush;
    assign pop       = inst_valid && !stall && !flush;
    // Live requests are contiguous words ending just below fetch_pc, oldest first.
    assign resp_pc   = fetch_pc_q - (32'(inflight_q) << 2);

    assign inst_mem_is_ready = issue;
    assign inst_mem_address  = fetch_pc_q;
    assign inst_valid        = occ_q != '0 && !exc_q;
    assign instruction       = inst_valid ? data_q[head_q] : 32'h0000_0013;
    assign inst_fetch_pc     = inst_valid ? pcs_q[head_q] : fetch_pc_q;
    assign exception         = exc_q;

    // Next-state: retire responses, issue, push/pop, and let flush override everything.
    always_comb begin
        inflight_ret = inflight_q - CW'(resp_keep);
        drop_ret     = drop_q - CW'(resp_drop);
        drop_sum     = {1'b0, drop_ret} + {1'b0, inflight_ret};
        fetch_pc_d   = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        inflight_d   = inflight_ret + CW'(issue);
        drop_d       = drop_ret;
        occ_d        = occ_q + CW'(push) - CW'(pop);
        head_d       = head_q + PW'(pop);
        tail_d       = tail_q + PW'(push);
        exc_d        = exc_q;
        if (flush) begin
            fetch_pc_d = redirect_pc;
            inflight_d = '0;
            drop_d     = drop_sum > {1'b0, DEPTH_C} ? DEPTH_C : drop_sum[CW-1:0];
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            exc_d      = exc_q || redirect_pc[1:0] != 2'b00;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET;
            occ_q      <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            exc_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            exc_q      <= exc_d;
        end
    end

    // Instruction and PC storage; contents are only meaningful below occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= inst_mem_read_data;
            pcs_q[tail_q]  <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam logic [31:0] RST = 32'h0000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset = 1'b1, st = 1'b0, fl = 1'b0, mv = 1'b0;
    logic [31:0] rpc = '0, md = '0;
    logic        ready, valid, exc;
    logic [31:0] addr, instr, ipc;

    fetch_queue #(.RESET(RST), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(st), .flush(fl), .redirect_pc(rpc),
        .inst_mem_is_ready(ready), .inst_mem_address(addr),
        .inst_mem_is_valid(mv), .inst_mem_read_data(md),
        .inst_valid(valid), .instruction(instr), .inst_fetch_pc(ipc), .exception(exc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; int t; } req_t;

    ent_t        headq[$];
    req_t        outq[$];
    logic [31:0] m_pc = RST;
    bit          m_exc = 0;
    int          cyc = 0, lat_fix = 1, mem_prob = 100, n_chk = 0, n_fail = 0;
    bit          spur = 0;
    logic        s_ready, s_valid, s_exc;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mdata(logic [31:0] pc);
        return {pc[7:0], pc[31:8]} ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; st = 1'b0; fl = 1'b0; mv = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", ipc, RST);
        headq.delete(); outq.delete(); m_pc = RST; m_exc = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive memory, compare against the model, then advance the model.
    task automatic cycle();
        req_t r;
        int live;
        bit e_ready, e_valid;
        mv = 1'b0; md = $urandom;
        if (outq.size() > 0) begin
            r = outq[0];
            mv = lat_fix > 0 ? (cyc >= r.t + lat_fix) : (cyc >= r.t + 1 && $urandom_range(0, 99) < mem_prob);
            if (mv) md = mdata(r.pc);
        end else mv = spur && $urandom_range(0, 9) == 0;
        #2;
        s_ready = ready; s_valid = valid; s_exc = exc; s_addr = addr; s_instr = instr; s_pc = ipc;
        live = 0;
        foreach (outq[i]) if (!outq[i].stale) live++;
        e_ready = !m_exc && !fl && (headq.size() + live < DEPTH);
        e_valid = !m_exc && headq.size() > 0;
        chk("ready", {31'b0, s_ready}, {31'b0, e_ready});
        chk("addr", s_addr, m_pc);
        chk("valid", {31'b0, s_valid}, {31'b0, e_valid});
        chk("exception", {31'b0, s_exc}, {31'b0, m_exc});
        if (e_valid) begin
            chk("instruction", s_instr, headq[0].data);
            chk("inst_pc", s_pc, headq[0].pc);
        end
        if (e_valid && !st && !fl) void'(headq.pop_front());
        if (mv && outq.size() > 0) begin
            r = outq.pop_front();
            if (!r.stale && !fl) headq.push_back('{r.pc, md});
        end
        if (fl) begin
            headq.delete();
            for (int i = 0; i < outq.size(); i++) outq[i].stale = 1;
            if (rpc[1:0] != 2'b00) m_exc = 1;
            m_pc = rpc;
        end else if (e_ready) begin
            outq.push_back('{m_pc, 1'b0, cyc});
            m_pc += 4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_head(string n, logic [31:0] pc);
        int k = 0;
        do begin cycle(); k++; end while (!s_valid && k < 20);
        chk({n, "_seen"}, {31'b0, s_valid}, 1);
        chk(n, s_pc, pc);
    endtask

    initial begin
        int n;
        do_reset();
        // Latency-1 streaming after reset.
        lat_fix = 1;
        cycle(); chk("first_addr", s_addr, 32'h0); chk("first_ready", {31'b0, s_ready}, 1);
        chk("first_valid", {31'b0, s_valid}, 0);
        cycle(); chk("second_addr", s_addr, 32'h4); chk("second_valid", {31'b0, s_valid}, 0);
        cycle(); chk("third_addr", s_addr, 32'h8); chk("head_valid", {31'b0, s_valid}, 1);
        chk("head_pc", s_pc, 32'h0); chk("head_instr", s_instr, mdata(32'h0));
        repeat (6) cycle();
        // Stall held: the credit limit allows exactly DEPTH requests.
        do_reset();
        st = 1'b1; n = 0;
        repeat (10) begin cycle(); n += int'(s_ready); end
        chk("stall_requests", n, 4);
        chk("stall_head_pc", s_pc, 32'h0);
        chk("stall_ready", {31'b0, s_ready}, 0);
        st = 1'b0;
        repeat (12) cycle();
        // Reset with a full queue returns outputs to reset values immediately.
        st = 1'b1;
        repeat (10) cycle();
        chk("full_valid", {31'b0, s_valid}, 1);
        do_reset();
        st = 1'b0;
        cycle(); chk("refetch_addr", s_addr, RST); chk("refetch_ready", {31'b0, s_ready}, 1);
        // Three in flight at latency 3, then redirect.
        do_reset();
        lat_fix = 3;
        repeat (3) cycle();
        fl = 1'b1; rpc = 32'h100;
        cycle(); chk("flush_ready", {31'b0, s_ready}, 0);
        fl = 1'b0;
        wait_head("redirect_pc", 32'h100);
        // Back-to-back redirects with responses pending.
        repeat (3) cycle();
        fl = 1'b1; rpc = 32'h200; cycle();
        rpc = 32'h300; cycle();
        fl = 1'b0;
        wait_head("second_redirect_pc", 32'h300);
        repeat (4) cycle();
        // Misaligned redirect locks fetching until reset.
        fl = 1'b1; rpc = 32'h102; cycle();
        fl = 1'b0; cycle();
        chk("exc_set", {31'b0, s_exc}, 1);
        chk("exc_ready", {31'b0, s_ready}, 0);
        repeat (8) cycle();
        chk("exc_ready_held", {31'b0, s_ready}, 0);
        chk("exc_valid_held", {31'b0, s_valid}, 0);
        do_reset();
        // Randomized traffic.
        spur = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                lat_fix = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 4));
                mem_prob = $urandom_range(20, 100);
            end
            st = $urandom_range(0, 99) < 30;
            fl = $urandom_range(0, 99) < 5 && outq.size() <= DEPTH;
            rpc = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 14) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle();
            fl = 1'b0;
            if (m_exc && $urandom_range(0, 29) == 0) do_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
